// File: rtl/ipml_fifo_v1_8_sync_fifo_if.sv
// ipml_fifo_v1_8_sync_fifo_if
// Bundles the write side, read side and status outputs of the synchronous FIFO.
//   master : producer/consumer side (drives wr_data, wr_en, rd_en)
//   slave  : FIFO side (drives flags, level, rd_data, overflow/underflow)
// Handshake: a write is accepted in a cycle iff wr_en=1 and wr_full=0; a read
// (or FWFT pop) is accepted iff rd_en=1 and rd_empty=0. Both flags are
// registered state, so acceptance never depends on the other side's request.
// A request made against a blocking flag is dropped and reported by a
// one-cycle overflow/underflow pulse on the following cycle.
interface ipml_fifo_v1_8_sync_fifo_if #(
  parameter int c_DEPTH_WIDTH = 10,
  parameter int c_DATA_WIDTH  = 32
);
  logic [c_DATA_WIDTH-1:0]  wr_data;
  logic                     wr_en;
  logic                     wr_full;
  logic                     almost_full;
  logic                     rd_en;
  logic [c_DATA_WIDTH-1:0]  rd_data;
  logic                     rd_empty;
  logic                     almost_empty;
  logic [c_DEPTH_WIDTH:0]   water_level;
  logic                     overflow;
  logic                     underflow;

  modport master (
    output wr_data, wr_en, rd_en,
    input  wr_full, almost_full, rd_data, rd_empty, almost_empty,
           water_level, overflow, underflow
  );

  modport slave (
    input  wr_data, wr_en, rd_en,
    output wr_full, almost_full, rd_data, rd_empty, almost_empty,
           water_level, overflow, underflow
  );
endinterface

// File: rtl/ipml_fifo_v1_8_sync_fifo.sv
// ipml_fifo_v1_8_sync_fifo
// Single-clock FIFO with 2^c_DEPTH_WIDTH words of inferred RAM.
//   clk  : single clock, everything on the rising edge
//   rst  : synchronous, active-high; clears pointers, level, flags, rd_data
//   bus  : slave modport of ipml_fifo_v1_8_sync_fifo_if (write port, read
//          port, wr_full/almost_full, rd_empty/almost_empty, water_level,
//          overflow/underflow pulses)
// c_FWFT=0: rd_data is a registered RAM read, updated one cycle after an
//           accepted read and held otherwise.
// c_FWFT=1: the same registered RAM read feeds a one-word output stage that
//           always holds the head word; rd_en pops it.
module ipml_fifo_v1_8_sync_fifo #(
  parameter int c_DEPTH_WIDTH      = 10,
  parameter int c_DATA_WIDTH       = 32,
  parameter int c_FWFT             = 0,
  parameter int c_ALMOST_FULL_NUM  = 2**c_DEPTH_WIDTH - 4,
  parameter int c_ALMOST_EMPTY_NUM = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  ipml_fifo_v1_8_sync_fifo_if.slave    bus
);

  localparam int LW    = c_DEPTH_WIDTH + 1;
  localparam int DEPTH = 2**c_DEPTH_WIDTH;

  localparam logic [c_DEPTH_WIDTH:0] LVL_FULL = LW'(DEPTH);
  localparam logic [c_DEPTH_WIDTH:0] LVL_AF   = LW'(c_ALMOST_FULL_NUM);
  localparam logic [c_DEPTH_WIDTH:0] LVL_AE   = LW'(c_ALMOST_EMPTY_NUM);
  localparam logic [c_DEPTH_WIDTH:0] LVL_ONE  = LW'(1);
  localparam bit                     FWFT     = (c_FWFT != 0);

  logic [c_DATA_WIDTH-1:0]  mem [DEPTH];
  logic [c_DEPTH_WIDTH-1:0] wr_ptr;
  logic [c_DEPTH_WIDTH-1:0] rd_ptr;
  logic [c_DEPTH_WIDTH:0]   level;
  logic [c_DEPTH_WIDTH:0]   level_nxt;
  logic [c_DEPTH_WIDTH:0]   ram_cnt;
  logic                     stage_vld;
  logic                     stage_vld_nxt;
  logic [c_DATA_WIDTH-1:0]  dout;
  logic                     wr_full;
  logic                     rd_empty;
  logic                     wr_acc;
  logic                     rd_acc;
  logic                     ram_rd;
  logic                     ovf_q;
  logic                     udf_q;

  always_comb begin
    wr_full       = (level == LVL_FULL);
    // Words still in RAM; the output stage word (FWFT only) is part of level.
    ram_cnt       = level - LW'(stage_vld);
    rd_empty      = FWFT ? ~stage_vld : (level == '0);
    wr_acc        = bus.wr_en & ~wr_full;
    rd_acc        = bus.rd_en & ~rd_empty;

    // In FWFT the RAM is read whenever the stage is (or is about to become)
    // free and RAM holds a word, which gives full-rate back-to-back pops.
    if (FWFT) begin
      ram_rd = (ram_cnt != '0) & (~stage_vld | rd_acc);
    end else begin
      ram_rd = rd_acc;
    end

    stage_vld_nxt = stage_vld;
    if (FWFT) begin
      if (ram_rd) begin
        stage_vld_nxt = 1'b1;
      end else if (rd_acc) begin
        stage_vld_nxt = 1'b0;
      end
    end

    level_nxt = level;
    case ({wr_acc, rd_acc})
      2'b10:   level_nxt = level + LVL_ONE;
      2'b01:   level_nxt = level - LVL_ONE;
      default: level_nxt = level;
    endcase
  end

  // Storage: no reset so it maps onto block RAM. Read and write addresses
  // never collide: a read needs a RAM word and a write needs a free slot.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      stage_vld <= 1'b0;
      dout      <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (ram_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout   <= mem[rd_ptr];
      end
      level     <= level_nxt;
      stage_vld <= stage_vld_nxt;
      ovf_q     <= bus.wr_en & wr_full;
      udf_q     <= bus.rd_en & rd_empty;
    end
  end

  assign bus.wr_full      = wr_full;
  assign bus.rd_empty     = rd_empty;
  assign bus.almost_full  = (level >= LVL_AF);
  assign bus.almost_empty = (level <= LVL_AE);
  assign bus.water_level  = level;
  assign bus.rd_data      = dout;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule

// File: doc/ipml_fifo_v1_8_sync_fifo.md
IPML_FIFO_V1_8_SYNC_FIFO -- requirements
Module: ipml_fifo_v1_8_sync_fifo

Interface
REQ-001 SHALL have parameter c_DEPTH_WIDTH, default 10, log2 of capacity, legal 2..20.
REQ-002 SHALL have parameter c_DATA_WIDTH, default 32, data width, legal 1..1152.
REQ-003 SHALL have parameter c_FWFT, default 0; 0 = standard read, 1 = first-word-fall-through.
REQ-004 SHALL have parameter c_ALMOST_FULL_NUM, default 2^c_DEPTH_WIDTH-4; almost-full threshold in words.
REQ-005 SHALL have parameter c_ALMOST_EMPTY_NUM, default 4; almost-empty threshold in words.
REQ-006 clk  in  1  single clock, all logic on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 wr_data  in  c_DATA_WIDTH  write data.
REQ-009 wr_en  in  1  write request.
REQ-010 wr_full  out  1  capacity reached.
REQ-011 almost_full  out  1  level >= c_ALMOST_FULL_NUM.
REQ-012 rd_en  in  1  read request (pop in FWFT).
REQ-013 rd_data  out  c_DATA_WIDTH  read data.
REQ-014 rd_empty  out  1  no word readable.
REQ-015 almost_empty  out  1  level <= c_ALMOST_EMPTY_NUM.
REQ-016 water_level  out  c_DEPTH_WIDTH+1  stored word count, 0..2^c_DEPTH_WIDTH.
REQ-017 overflow  out  1  one-cycle pulse, write rejected.
REQ-018 underflow  out  1  one-cycle pulse, read rejected.

Function
REQ-019 Capacity SHALL be 2^c_DEPTH_WIDTH words in both modes; storage is inferred RAM, no vendor primitive.
REQ-020 Write SHALL be accepted iff wr_en=1 and wr_full=0 in that cycle; read accepted iff rd_en=1 and rd_empty=0.
REQ-021 Acceptance SHALL use registered flag values of the current cycle; wr_en at full with simultaneous accepted read SHALL still be rejected.
REQ-022 Rejected write SHALL pulse overflow on the next cycle; rejected read SHALL pulse underflow on the next cycle; storage, pointers, level unchanged.
REQ-023 Pointers SHALL be c_DEPTH_WIDTH bits and wrap modulo 2^c_DEPTH_WIDTH without gaps.
REQ-024 water_level SHALL update one cycle after acceptance: +1 write only, -1 read only, unchanged for both.
REQ-025 wr_full SHALL equal (water_level == 2^c_DEPTH_WIDTH); almost_full and almost_empty SHALL be derived from the registered level, same cycle.
REQ-026 c_FWFT=0: rd_empty SHALL equal (water_level == 0); rd_data SHALL present the popped word one cycle after read acceptance and hold otherwise.
REQ-027 c_FWFT=0: first write into empty FIFO at cycle N SHALL deassert rd_empty at N+1.
REQ-028 c_FWFT=1: SHALL use a one-word output stage; rd_empty SHALL be 1 whenever the output stage is invalid; rd_data SHALL show the head word whenever rd_empty=0.
REQ-029 c_FWFT=1: first write into empty FIFO at cycle N SHALL present the word on rd_data with rd_empty=0 at N+2.
REQ-030 c_FWFT=1: accepted pop SHALL load the next word into the output stage by the following cycle when available (back-to-back pops at full rate), else set rd_empty=1.
REQ-031 c_FWFT=1: water_level SHALL count RAM words plus the output stage word.
REQ-032 Data order SHALL be strict FIFO; no word lost or duplicated across wrap-around.

Reset
REQ-033 rst=1 at a rising edge SHALL, at that edge, clear pointers and output stage and set water_level=0, rd_empty=1, wr_full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, rd_data=0.
REQ-034 wr_en/rd_en SHALL be ignored while rst=1; reset mid-operation SHALL discard all stored words; RAM contents need not be cleared.

Verification
REQ-035 c_DEPTH_WIDTH=4, c_FWFT=0: 16 writes 0..15 -> wr_full=1, level=16; 17th write -> overflow pulse; 16 reads -> 0..15 in order, rd_empty=1.
REQ-036 c_FWFT=1: single write 0xA5 at cycle N -> rd_data=0xA5, rd_empty=0 at N+2; pop -> rd_empty=1 next cycle, level=0.
REQ-037 Simultaneous rd_en/wr_en at level 5 for 100 cycles -> level stays 5, output sequence continuous across 6+ pointer wraps.
REQ-038 Full FIFO, rd_en=1 and wr_en=1 -> read accepted, write rejected, overflow=1, level 15; at empty, rd_en=1 -> underflow=1, rd_data unchanged.
REQ-039 Level 10, rst asserted one cycle with wr_en=1 -> level=0, rd_empty=1, all flags reset values, next write returns only new data.
REQ-040 c_ALMOST_FULL_NUM=12, c_ALMOST_EMPTY_NUM=3: sweep level 0..16..0 -> almost_full=1 exactly for level>=12, almost_empty=1 exactly for level<=3.
